p1_code_writer: RTL

- Player-1 side of the code exchange: records a secret sequence of press-duration symbols from the board keys into a 32-entry store, then seals it.
- Exposes a registered read port that the player-2 matcher scans.
- Enabled during the P1 turn; sits between the key inputs and the player-2 comparison logic.
- Runs on the game tick clock.

---
 rtl/p1_code_writer_pkg.sv | 18 +
 rtl/p1_code_writer_key_edge.sv | 17 +
 rtl/p1_code_writer.sv | 110 +++++++++++
 3 files changed

// File: rtl/p1_code_writer_pkg.sv
// Shared constants and state encoding for the code-exchange blocks.
package p1_code_writer_pkg;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int SYM_W  = 3;
  localparam logic [SYM_W-1:0] SYM_MAX = {SYM_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_SEALED = 2'd2
  } state_e;

  // Saturating +1 for a pending hold duration.
  function automatic logic [SYM_W-1:0] sat_inc(input logic [SYM_W-1:0] v);
    return (v == SYM_MAX) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/p1_code_writer_key_edge.sv
// Falling-edge detector for an active-low key; one pulse per press.
module p1_code_writer_key_edge (
  input  logic clock,
  input  logic resetn,
  input  logic key_i,
  output logic fall_o
);
  logic prev_q;

  // Track the key every cycle; released (1) after reset.
  always_ff @(posedge clock) begin
    if (!resetn) prev_q <= 1'b1;
    else         prev_q <= key_i;
  end

  assign fall_o = prev_q & ~key_i;
endmodule

// File: rtl/p1_code_writer.sv
// Player-1 code writer: records hold-duration symbols, seals, and serves reads.
module p1_code_writer
  import p1_code_writer_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              enable,
  input  logic              user_input,
  input  logic              next_input,
  input  logic              done_input,
  input  logic              clear,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [SYM_W-1:0]  rd_data,
  output logic [ADDR_W:0]   length,
  output logic [SYM_W-1:0]  hold_level,
  output logic              sealed,
  output logic              full,
  output logic              overflow
);
  state_e            state_q, state_d;
  logic [ADDR_W:0]   length_q, length_d;
  logic [SYM_W-1:0]  hold_q, hold_d;
  logic              ovf_q, ovf_d;
  logic [SYM_W-1:0]  rd_q;
  logic              mem_we;
  logic              next_ev, done_ev;
  logic [SYM_W-1:0]  mem [DEPTH];

  p1_code_writer_key_edge u_next (
    .clock(clock), .resetn(resetn), .key_i(next_input), .fall_o(next_ev)
  );
  p1_code_writer_key_edge u_done (
    .clock(clock), .resetn(resetn), .key_i(done_input), .fall_o(done_ev)
  );

  assign full = (length_q == (ADDR_W+1)'(DEPTH));

  // Next-state: clear wins, otherwise per-state recording rules.
  always_comb begin
    state_d  = state_q;
    length_d = length_q;
    hold_d   = hold_q;
    ovf_d    = ovf_q;
    mem_we   = 1'b0;
    if (clear) begin
      state_d  = S_IDLE;
      length_d = '0;
      hold_d   = '0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (enable) state_d = S_RECORD;
        S_RECORD: if (enable) begin
          if (!user_input) hold_d = sat_inc(hold_q);
          if (next_ev || done_ev) begin
            // Commit the pre-increment duration; a still-held key restarts at 1.
            if (hold_q != '0) begin
              if (!full) begin
                mem_we   = 1'b1;
                length_d = length_q + 1'b1;
              end else begin
                ovf_d = 1'b1;
              end
            end
            hold_d = user_input ? '0 : SYM_W'(1);
          end
          // Sealing an empty sequence is ignored.
          if (done_ev && (length_q != '0 || hold_q != '0)) state_d = S_SEALED;
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      length_q <= '0;
      hold_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      length_q <= length_d;
      hold_q   <= hold_d;
      ovf_q    <= ovf_d;
    end
  end

  // Symbol store write; contents survive reset, length masks stale entries.
  always_ff @(posedge clock) begin
    if (mem_we) mem[length_q[ADDR_W-1:0]] <= hold_q;
  end

  // Registered read; only valid, sealed entries are visible.
  always_ff @(posedge clock) begin
    if (!resetn)
      rd_q <= '0;
    else if (state_q == S_SEALED && {1'b0, rd_addr} < length_q)
      rd_q <= mem[rd_addr];
    else
      rd_q <= '0;
  end

  assign rd_data    = rd_q;
  assign length     = length_q;
  assign hold_level = hold_q;
  assign sealed     = (state_q == S_SEALED);
  assign overflow   = ovf_q;
endmodule
